tmp_readout: RTL and testbench

- Readout end of the temperature-sensor charge-balancing loop.
- Consumes the sensor controller's comparator decision (cmp), its sample strobe, and the src_n/snk charge-packet toggle streams over a conversion window.
- Accumulates a net charge-packet count and a comparator ones-density, then presents one signed conversion result to the host with a valid/ready handshake.
- Sits between the analog sequencer and the register/host interface.

---
 rtl/tmp_readout_pkg.sv | 26 ++
 rtl/tmp_readout_if.sv | 33 +++
 rtl/tmp_toggle_det.sv | 23 ++
 rtl/tmp_readout.sv | 202 ++++++++++++++++++++
 tb/tb_tmp_readout.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/tmp_readout_pkg.sv
// Shared types, default sizes and saturation limits for the temperature-sensor
// readout block.
package tmp_readout_pkg;

  localparam int N_SAMPLES_DEF = 64;
  localparam int SETTLE_DEF    = 4;
  localparam int CNT_W_DEF     = 8;
  localparam int ONES_W_DEF    = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Largest and smallest values of a w-bit two's-complement charge count
  function automatic int charge_max(input int w);
    return (32'sd1 <<< (w - 1)) - 32'sd1;
  endfunction

  function automatic int charge_min(input int w);
    return -(32'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/tmp_readout_if.sv
// Sequencer/host bundle of the readout: loop inputs in, conversion result and
// status out, result delivered under a valid/ready handshake.
interface tmp_readout_if
  import tmp_readout_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int ONES_W = ONES_W_DEF
);

  logic                     conv_active;
  logic                     sample;
  logic                     cmp;
  logic                     src_n;
  logic                     snk;
  logic                     res_ready;
  logic signed [CNT_W-1:0]  charge;
  logic        [ONES_W-1:0] ones;
  logic                     sat;
  logic                     res_valid;
  logic                     abort;
  logic                     busy;

  modport master (
    output conv_active, sample, cmp, src_n, snk, res_ready,
    input  charge, ones, sat, res_valid, abort, busy
  );

  modport slave (
    input  conv_active, sample, cmp, src_n, snk, res_ready,
    output charge, ones, sat, res_valid, abort, busy
  );

endinterface

// File: rtl/tmp_toggle_det.sv
// Level-change detector for a charge-packet line: flags a packet whenever the
// line differs from its value one cycle earlier.
module tmp_toggle_det (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_line,
  output logic o_event
);

  logic r_hist;

  // History follows the line every cycle so stale changes never surface later
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hist <= 1'b0;
    end else begin
      r_hist <= i_line;
    end
  end

  assign o_event = i_line ^ r_hist;

endmodule

// File: rtl/tmp_readout.sv
// Readout of the charge-balancing loop: counts net packets and comparator ones
// over a conversion window and hands one result to the host.
module tmp_readout
  import tmp_readout_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int SETTLE    = SETTLE_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int ONES_W    = ONES_W_DEF
) (
  input logic          i_clk,
  input logic          i_reset,
  tmp_readout_if.slave bus
);

  localparam int MAXC = (N_SAMPLES > SETTLE) ? N_SAMPLES : SETTLE;
  localparam int SC_W = $clog2(MAXC + 1);
  localparam logic [SC_W-1:0]         N_LAST = SC_W'(N_SAMPLES);
  localparam logic [SC_W-1:0]         S_LAST = SC_W'(SETTLE);
  localparam logic signed [CNT_W-1:0] C_MAX  = CNT_W'(charge_max(CNT_W));
  localparam logic signed [CNT_W-1:0] C_MIN  = CNT_W'(charge_min(CNT_W));

  state_t                  r_state,   w_state_nxt;
  logic [SC_W-1:0]         r_cnt,     w_cnt_nxt;
  logic signed [CNT_W-1:0] r_wcharge, w_wcharge_nxt;
  logic [ONES_W-1:0]       r_wones,   w_wones_nxt;
  logic                    r_wsat,    w_wsat_nxt;
  logic signed [CNT_W-1:0] r_charge,  w_charge_nxt;
  logic [ONES_W-1:0]       r_ones,    w_ones_nxt;
  logic                    r_sat,     w_sat_nxt;
  logic                    r_res_valid, w_res_valid_nxt;
  logic                    r_abort,   w_abort_nxt;
  logic                    r_busy,    w_busy_nxt;

  logic                    w_src_ev;
  logic                    w_snk_ev;
  logic [SC_W-1:0]         w_cnt_inc;
  logic signed [CNT_W-1:0] w_acc_charge;
  logic                    w_acc_sat;
  logic [ONES_W-1:0]       w_acc_ones;

  tmp_toggle_det u_src_det (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_line  (bus.src_n),
    .o_event (w_src_ev)
  );

  tmp_toggle_det u_snk_det (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_line  (bus.snk),
    .o_event (w_snk_ev)
  );

  // Working-value update for one ACCUM cycle, then FSM next state and outputs
  always_comb begin
    w_cnt_inc    = r_cnt + SC_W'(1);
    w_acc_charge = r_wcharge;
    w_acc_sat    = r_wsat;
    if (w_src_ev && !w_snk_ev) begin
      if (r_wcharge == C_MAX) begin
        w_acc_sat = 1'b1;
      end else begin
        w_acc_charge = r_wcharge + CNT_W'(1);
      end
    end else if (w_snk_ev && !w_src_ev) begin
      if (r_wcharge == C_MIN) begin
        w_acc_sat = 1'b1;
      end else begin
        w_acc_charge = r_wcharge - CNT_W'(1);
      end
    end else begin
      w_acc_charge = r_wcharge;
    end
    if (bus.sample) begin
      w_acc_ones = r_wones + {{(ONES_W-1){1'b0}}, bus.cmp};
    end else begin
      w_acc_ones = r_wones;
    end

    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_wcharge_nxt   = r_wcharge;
    w_wones_nxt     = r_wones;
    w_wsat_nxt      = r_wsat;
    w_charge_nxt    = r_charge;
    w_ones_nxt      = r_ones;
    w_sat_nxt       = r_sat;
    w_res_valid_nxt = r_res_valid;
    w_abort_nxt     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (bus.conv_active) begin
          w_cnt_nxt = SC_W'(0);
          if (S_LAST == SC_W'(0)) begin
            w_state_nxt   = ST_ACCUM;
            w_wcharge_nxt = CNT_W'(0);
            w_wones_nxt   = ONES_W'(0);
            w_wsat_nxt    = 1'b0;
          end else begin
            w_state_nxt = ST_SETTLE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (!bus.conv_active) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
        end else if (bus.sample) begin
          if (w_cnt_inc == S_LAST) begin
            w_state_nxt   = ST_ACCUM;
            w_cnt_nxt     = SC_W'(0);
            w_wcharge_nxt = CNT_W'(0);
            w_wones_nxt   = ONES_W'(0);
            w_wsat_nxt    = 1'b0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_ACCUM: begin
        if (!bus.conv_active) begin
          w_state_nxt = ST_IDLE;
          w_abort_nxt = 1'b1;
        end else begin
          w_wcharge_nxt = w_acc_charge;
          w_wones_nxt   = w_acc_ones;
          w_wsat_nxt    = w_acc_sat;
          // Final strobe publishes values that already include its own cmp/events
          if (bus.sample && (w_cnt_inc == N_LAST)) begin
            w_state_nxt     = ST_HOLD;
            w_cnt_nxt       = SC_W'(0);
            w_charge_nxt    = w_acc_charge;
            w_ones_nxt      = w_acc_ones;
            w_sat_nxt       = w_acc_sat;
            w_res_valid_nxt = 1'b1;
          end else if (bus.sample) begin
            w_cnt_nxt = w_cnt_inc;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          w_state_nxt     = ST_IDLE;
          w_res_valid_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_HOLD;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_ACCUM);
  end

  // State, working accumulators and registered outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= SC_W'(0);
      r_wcharge   <= CNT_W'(0);
      r_wones     <= ONES_W'(0);
      r_wsat      <= 1'b0;
      r_charge    <= CNT_W'(0);
      r_ones      <= ONES_W'(0);
      r_sat       <= 1'b0;
      r_res_valid <= 1'b0;
      r_abort     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_wcharge   <= w_wcharge_nxt;
      r_wones     <= w_wones_nxt;
      r_wsat      <= w_wsat_nxt;
      r_charge    <= w_charge_nxt;
      r_ones      <= w_ones_nxt;
      r_sat       <= w_sat_nxt;
      r_res_valid <= w_res_valid_nxt;
      r_abort     <= w_abort_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  assign bus.charge    = r_charge;
  assign bus.ones      = r_ones;
  assign bus.sat       = r_sat;
  assign bus.res_valid = r_res_valid;
  assign bus.abort     = r_abort;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_tmp_readout.sv
// Directed bench for tmp_readout: a default-width instance and a CNT_W=4
// instance share one stimulus stream, so their FSMs run in lockstep.
module tb_tmp_readout;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic conv_active = 1'b0;
  logic sample = 1'b0;
  logic cmp = 1'b0;
  logic src_n = 1'b0;
  logic snk = 1'b0;
  logic res_ready = 1'b0;
  int n_checks = 0;
  int n_fails = 0;

  tmp_readout_if #(.CNT_W(8), .ONES_W(7)) bus8 ();
  tmp_readout_if #(.CNT_W(4), .ONES_W(7)) bus4 ();

  assign bus8.conv_active = conv_active;
  assign bus8.sample      = sample;
  assign bus8.cmp         = cmp;
  assign bus8.src_n       = src_n;
  assign bus8.snk         = snk;
  assign bus8.res_ready   = res_ready;
  assign bus4.conv_active = conv_active;
  assign bus4.sample      = sample;
  assign bus4.cmp         = cmp;
  assign bus4.src_n       = src_n;
  assign bus4.snk         = snk;
  assign bus4.res_ready   = res_ready;

  tmp_readout #(.N_SAMPLES(64), .SETTLE(4), .CNT_W(8), .ONES_W(7)) u_dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus8)
  );

  tmp_readout #(.N_SAMPLES(64), .SETTLE(4), .CNT_W(4), .ONES_W(7)) u_dut4 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus4)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic s, input logic c, input logic ts, input logic tk);
    sample = s;
    cmp = c;
    if (ts) src_n = ~src_n;
    if (tk) snk = ~snk;
    tick();
    sample = 1'b0;
  endtask

  task automatic settle(input logic tog);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, tog, tog && (i % 2 == 0));
  endtask

  task automatic begin_conv(input logic tog);
    conv_active = 1'b1;
    tick();
    settle(tog);
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    conv_active = 1'b0;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_checks++; if ({bus8.charge, bus8.ones, bus8.sat, bus8.res_valid, bus8.abort, bus8.busy} !== 19'd0) begin n_fails++; $display("FAIL reset_outputs: got %h expected 0", {bus8.charge, bus8.ones, bus8.sat, bus8.res_valid, bus8.abort, bus8.busy}); end
    reset = 1'b0;
    tick();
    n_checks++; if (bus8.busy !== 1'b0) begin n_fails++; $display("FAIL reset_idle_busy: got %b expected 0", bus8.busy); end
  endtask

  task automatic test_basic();
    begin_conv(1'b0);
    n_checks++; if (bus8.busy !== 1'b1) begin n_fails++; $display("FAIL basic_busy: got %b expected 1", bus8.busy); end
    for (int i = 0; i < 64; i++) begin
      if (i < 9) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, i == 63, (i >= 20) && (i <= 22));
      if (i == 62) begin
        n_checks++; if (bus8.res_valid !== 1'b0) begin n_fails++; $display("FAIL basic_early_valid: got %b expected 0", bus8.res_valid); end
      end
    end
    n_checks++; if (bus8.res_valid !== 1'b1) begin n_fails++; $display("FAIL basic_valid: got %b expected 1", bus8.res_valid); end
    n_checks++; if (bus8.charge !== 8'sd7) begin n_fails++; $display("FAIL basic_charge: got %0d expected 7", bus8.charge); end
    n_checks++; if (bus8.ones !== 7'd64) begin n_fails++; $display("FAIL basic_ones: got %0d expected 64", bus8.ones); end
    n_checks++; if (bus8.sat !== 1'b0) begin n_fails++; $display("FAIL basic_sat: got %b expected 0", bus8.sat); end
    n_checks++; if (bus8.busy !== 1'b0) begin n_fails++; $display("FAIL basic_busy_hold: got %b expected 0", bus8.busy); end
    n_checks++; if ({bus4.charge, bus4.sat} !== 5'b0101_1) begin n_fails++; $display("FAIL basic_w4: got charge %0d sat %b expected 5 1", bus4.charge, bus4.sat); end
    release_result();
    n_checks++; if (bus8.res_valid !== 1'b0) begin n_fails++; $display("FAIL basic_release: got %b expected 0", bus8.res_valid); end
  endtask

  task automatic test_simultaneous();
    begin_conv(1'b1);
    for (int i = 0; i < 64; i++) cyc(1'b1, (i % 2) == 1, i < 5, i < 5);
    n_checks++; if (bus8.charge !== 8'sd0) begin n_fails++; $display("FAIL simul_charge: got %0d expected 0", bus8.charge); end
    n_checks++; if (bus8.ones !== 7'd32) begin n_fails++; $display("FAIL simul_ones: got %0d expected 32", bus8.ones); end
    n_checks++; if ({bus4.charge, bus4.sat} !== 5'b0000_0) begin n_fails++; $display("FAIL simul_w4: got charge %0d sat %b expected 0 0", bus4.charge, bus4.sat); end
    release_result();
  endtask

  task automatic test_saturation();
    begin_conv(1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, i < 12, 1'b0);
    n_checks++; if (bus4.charge !== 4'sd7) begin n_fails++; $display("FAIL sat_pos_charge: got %0d expected 7", bus4.charge); end
    n_checks++; if (bus4.sat !== 1'b1) begin n_fails++; $display("FAIL sat_pos_flag: got %b expected 1", bus4.sat); end
    n_checks++; if ({bus8.charge, bus8.sat, bus8.ones} !== {8'd12, 1'b0, 7'd0}) begin n_fails++; $display("FAIL sat_pos_w8: got charge %0d sat %b ones %0d expected 12 0 0", bus8.charge, bus8.sat, bus8.ones); end
    release_result();
    begin_conv(1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, 1'b0, i < 9);
    n_checks++; if (bus4.charge !== 4'b1000) begin n_fails++; $display("FAIL sat_neg_charge: got %0d expected -8", bus4.charge); end
    n_checks++; if (bus4.sat !== 1'b1) begin n_fails++; $display("FAIL sat_neg_flag: got %b expected 1", bus4.sat); end
    n_checks++; if ({bus8.charge, bus8.sat} !== {8'hF7, 1'b0}) begin n_fails++; $display("FAIL sat_neg_w8: got charge %0d sat %b expected -9 0", bus8.charge, bus8.sat); end
    release_result();
  endtask

  task automatic test_abort();
    begin_conv(1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 1'b1, i < 6, 1'b0);
    n_checks++; if ({bus8.abort, bus8.busy} !== 2'b01) begin n_fails++; $display("FAIL abort_pre: got abort %b busy %b expected 0 1", bus8.abort, bus8.busy); end
    conv_active = 1'b0;
    sample = 1'b1;
    src_n = ~src_n;
    tick();
    sample = 1'b0;
    n_checks++; if (bus8.abort !== 1'b1) begin n_fails++; $display("FAIL abort_pulse: got %b expected 1", bus8.abort); end
    n_checks++; if ({bus8.busy, bus8.res_valid} !== 2'b00) begin n_fails++; $display("FAIL abort_status: got busy %b valid %b expected 0 0", bus8.busy, bus8.res_valid); end
    n_checks++; if ({bus8.charge, bus8.ones} !== {8'hF7, 7'd0}) begin n_fails++; $display("FAIL abort_prior: got charge %0d ones %0d expected -9 0", bus8.charge, bus8.ones); end
    tick();
    n_checks++; if (bus8.abort !== 1'b0) begin n_fails++; $display("FAIL abort_width: got %b expected 0", bus8.abort); end
  endtask

  task automatic test_hold();
    begin_conv(1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, i < 30, (i >= 40) && (i < 43), 1'b0);
    n_checks++; if ({bus8.res_valid, bus8.charge, bus8.ones} !== {1'b1, 8'd3, 7'd30}) begin n_fails++; $display("FAIL hold_result: got valid %b charge %0d ones %0d expected 1 3 30", bus8.res_valid, bus8.charge, bus8.ones); end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 1'b1, 1'b1, (k % 2) == 0);
      n_checks++; if ({bus8.res_valid, bus8.charge, bus8.ones} !== {1'b1, 8'd3, 7'd30}) begin n_fails++; $display("FAIL hold_stable: cycle %0d got valid %b charge %0d ones %0d expected 1 3 30", k, bus8.res_valid, bus8.charge, bus8.ones); end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_checks++; if ({bus8.res_valid, bus8.busy} !== 2'b00) begin n_fails++; $display("FAIL hold_ack: got valid %b busy %b expected 0 0", bus8.res_valid, bus8.busy); end
    tick();
    n_checks++; if (bus8.busy !== 1'b1) begin n_fails++; $display("FAIL hold_restart: got busy %b expected 1", bus8.busy); end
    settle(1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++; if ({bus8.res_valid, bus8.charge, bus8.ones} !== {1'b1, 8'd0, 7'd0}) begin n_fails++; $display("FAIL hold_fresh: got valid %b charge %0d ones %0d expected 1 0 0", bus8.res_valid, bus8.charge, bus8.ones); end
    release_result();
  endtask

  task automatic test_reset_mid();
    begin_conv(1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    tick();
    n_checks++; if ({bus8.charge, bus8.ones, bus8.sat, bus8.res_valid, bus8.abort, bus8.busy} !== 19'd0) begin n_fails++; $display("FAIL rst_mid_w8: got %h expected 0", {bus8.charge, bus8.ones, bus8.sat, bus8.res_valid, bus8.abort, bus8.busy}); end
    n_checks++; if ({bus4.charge, bus4.ones, bus4.sat, bus4.res_valid, bus4.abort, bus4.busy} !== 15'd0) begin n_fails++; $display("FAIL rst_mid_w4: got %h expected 0", {bus4.charge, bus4.ones, bus4.sat, bus4.res_valid, bus4.abort, bus4.busy}); end
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (bus8.busy !== 1'b1) begin n_fails++; $display("FAIL rst_mid_restart: got busy %b expected 1", bus8.busy); end
    settle(1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b1, i < 5, 1'b0, (i == 10) || (i == 50));
    n_checks++; if ({bus8.res_valid, bus8.charge, bus8.ones, bus8.sat} !== {1'b1, 8'hFE, 7'd5, 1'b0}) begin n_fails++; $display("FAIL rst_mid_result: got valid %b charge %0d ones %0d sat %b expected 1 -2 5 0", bus8.res_valid, bus8.charge, bus8.ones, bus8.sat); end
    n_checks++; if (bus4.charge !== 4'hE) begin n_fails++; $display("FAIL rst_mid_w4_charge: got %0d expected -2", bus4.charge); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_saturation();
    test_abort();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
